// File: rtl/pg_add_arbiter_pkg.sv
// Shared constants and types for the two-requester pipelined adder.
// Holds the default width, requester ids and the per-stage control bundle.
package pg_add_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 128;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Control fields that travel alongside the p / g-or-carry payload of
    // every pipeline stage.
    typedef struct packed {
        logic cin;
        logic id;
        logic valid;
    } stage_ctl_t;

endpackage

// File: rtl/pg_add_arbiter_pg.sv
// Bitwise propagate/generate generator with add/subtract operand select.
// Ports: x, y operands; sub selects x-y; p, g per-bit terms; cin carry-in.
module pg_add_arbiter_pg #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g,
    output logic             cin
);

    logic [WIDTH-1:0] y_eff;

    // Subtraction is x + ~y + 1: invert y and inject the +1 as carry-in.
    assign y_eff = sub ? ~y : y;
    assign p     = x ^ y_eff;
    assign g     = x & y_eff;
    assign cin   = sub;

endmodule

// File: rtl/prefix_carry.sv
// Kogge-Stone parallel-prefix carry network, log2(WIDTH) levels, combinational.
// Ports: p, g per-bit propagate/generate; cin carry-in; c carries c[WIDTH:1].
module prefix_carry #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    input  logic             cin,
    output logic [WIDTH:1]   c
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] gl [LEVELS+1];
    logic [WIDTH-1:0] pl [LEVELS];

    // Folding cin into bit 0 makes every group generate already include
    // the carry-in, so gl at the last level is directly the carry out of
    // each bit position.
    assign gl[0] = {g[WIDTH-1:1], g[0] | (p[0] & cin)};
    assign pl[0] = p;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_comb
                assign gl[k+1][i] = gl[k][i]
                                  | (pl[k][i] & gl[k][i-(1<<k)]);
                if (k < LEVELS - 1) begin : g_p
                    assign pl[k+1][i] = pl[k][i] & pl[k][i-(1<<k)];
                end
            end else begin : g_pass
                assign gl[k+1][i] = gl[k][i];
                if (k < LEVELS - 1) begin : g_p
                    assign pl[k+1][i] = pl[k][i];
                end
            end
        end
    end

    assign c = gl[LEVELS];

endmodule

// File: rtl/pg_add_arbiter.sv
// Round-robin arbiter sharing a 3-stage add/sub pipeline between two ports.
// Ports: clk/rst; req0_*/req1_* valid/ready operand ports; res_* result port.
module pg_add_arbiter
    import pg_add_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic             req1_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);

    // gc holds g in stage 1 and the carries c[WIDTH:1] in stage 2.
    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] gc;
        stage_ctl_t       ctl;
    } stage_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             id;
        logic             valid;
    } res_t;

    stage_t s1_q, s1_d;
    stage_t s2_q, s2_d;
    res_t   s3_q, s3_d;
    logic   rr_last_q, rr_last_d;

    logic             advance;
    logic             grant0;
    logic             grant1;
    logic             take;
    logic             sel_id;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic             sel_sub;
    logic [WIDTH-1:0] pg_p;
    logic [WIDTH-1:0] pg_g;
    logic             pg_cin;
    logic [WIDTH:1]   carry;
    logic [WIDTH:0]   c_full;

    // The whole pipeline moves as one; only a held result stops it.
    assign advance = !s3_q.valid || res_ready;

    // On a tie the requester that did not win last time is granted.
    assign grant0 = req0_valid && (!req1_valid || rr_last_q == REQ1);
    assign grant1 = req1_valid && (!req0_valid || rr_last_q == REQ0);

    assign req0_ready = grant0 && advance && !rst;
    assign req1_ready = grant1 && advance && !rst;
    assign take       = req0_ready || req1_ready;

    assign sel_id  = grant1 ? REQ1 : REQ0;
    assign sel_x   = grant1 ? req1_x : req0_x;
    assign sel_y   = grant1 ? req1_y : req0_y;
    assign sel_sub = grant1 ? req1_sub : req0_sub;

    pg_add_arbiter_pg #(
        .WIDTH (WIDTH)
    ) u_pg (
        .x   (sel_x),
        .y   (sel_y),
        .sub (sel_sub),
        .p   (pg_p),
        .g   (pg_g),
        .cin (pg_cin)
    );

    prefix_carry #(
        .WIDTH (WIDTH)
    ) u_prefix (
        .p   (s1_q.p),
        .g   (s1_q.gc),
        .cin (s1_q.ctl.cin),
        .c   (carry)
    );

    assign c_full = {s2_q.gc, s2_q.ctl.cin};

    always_comb begin
        s1_d      = s1_q;
        s2_d      = s2_q;
        s3_d      = s3_q;
        rr_last_d = rr_last_q;

        if (advance) begin
            s1_d.p         = pg_p;
            s1_d.gc        = pg_g;
            s1_d.ctl.cin   = pg_cin;
            s1_d.ctl.id    = sel_id;
            s1_d.ctl.valid = take;

            s2_d.p   = s1_q.p;
            s2_d.gc  = carry;
            s2_d.ctl = s1_q.ctl;

            s3_d.sum   = s2_q.p ^ c_full[WIDTH-1:0];
            s3_d.cout  = c_full[WIDTH];
            s3_d.id    = s2_q.ctl.id;
            s3_d.valid = s2_q.ctl.valid;
        end

        if (take) begin
            rr_last_d = sel_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            rr_last_q <= REQ1;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign res_valid = s3_q.valid;
    assign res_sum   = s3_q.sum;
    assign res_cout  = s3_q.cout;
    assign res_id    = s3_q.id;

endmodule

// File: tb/tb_pg_add_arbiter.sv
// Self-checking bench for pg_add_arbiter: scenario tasks plus a
// scoreboard fed at request transfer and drained at result transfer.
module tb_pg_add_arbiter;
    import pg_add_arbiter_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_x, req0_y;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_x, req1_y;
    logic         res_valid, res_ready, res_cout, res_id;
    logic [W-1:0] res_sum;

    int checks   = 0;
    int failures = 0;
    int accepted = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
    } exp_t;

    exp_t sb[$];

    pg_add_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_sub   (req1_sub),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_op(input logic [W-1:0] x,
                                    input logic [W-1:0] y,
                                    input logic sub,
                                    input logic id);
        exp_t         e;
        logic [W:0]   r;
        if (sub) begin
            r      = {1'b0, x} - {1'b0, y};
            e.cout = ~r[W];
        end else begin
            r      = {1'b0, x} + {1'b0, y};
            e.cout = r[W];
        end
        e.sum = r[W-1:0];
        e.id  = id;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] r;
        r = '0;
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = '1;
            2: r = W'(1);
            default: begin
                for (int i = 0; i < (W + 31) / 32; i++) begin
                    r = (r << 32) | W'($urandom);
                end
            end
        endcase
        return r;
    endfunction

    // Scoreboard: push at request transfer, pop at result transfer.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (res_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_extra: got sum=%h id=%0d, required none",
                             res_sum, res_id);
                end else begin
                    e = sb.pop_front();
                    if (res_sum !== e.sum || res_cout !== e.cout
                        || res_id !== e.id) begin
                        failures++;
                        $display("FAIL sb_result: got sum=%h c=%b id=%b, required sum=%h c=%b id=%b",
                                 res_sum, res_cout, res_id, e.sum, e.cout, e.id);
                    end
                end
            end
            if (req0_valid && req0_ready) begin
                sb.push_back(ref_op(req0_x, req0_y, req0_sub, REQ0));
                accepted++;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(ref_op(req1_x, req1_y, req1_sub, REQ1));
                accepted++;
            end
            checks++;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                failures++;
                $display("FAIL one_hot_ready: got both 1, required at most one");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic id, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic sub);
        bit ok;
        ok = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_x = x; req1_y = y; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_x = x; req0_y = y; req0_sub = sub;
        end
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        step();
        idle();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout: got ready=0, required 1 within 20");
        end
    endtask

    task automatic wait_result(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            seen = res_valid;
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !res_valid;
        end
        step();
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        res_ready  = 1'b1;
        req0_valid = 1'b1; req0_x = W'(9); req0_y = W'(4); req0_sub = 1'b0;
        req1_valid = 1'b1; req1_x = W'(2); req1_y = W'(1); req1_sub = 1'b1;
        step();
        step();
        @(negedge clk);
        checks += 6;
        if (res_valid !== 1'b0) begin
            failures++; $display("FAIL rst_valid: got %b, required 0", res_valid);
        end
        if (res_sum !== '0) begin
            failures++; $display("FAIL rst_sum: got %h, required 0", res_sum);
        end
        if (res_cout !== 1'b0) begin
            failures++; $display("FAIL rst_cout: got %b, required 0", res_cout);
        end
        if (res_id !== 1'b0) begin
            failures++; $display("FAIL rst_id: got %b, required 0", res_id);
        end
        if (req0_ready !== 1'b0) begin
            failures++; $display("FAIL rst_rdy0: got %b, required 0", req0_ready);
        end
        if (req1_ready !== 1'b0) begin
            failures++; $display("FAIL rst_rdy1: got %b, required 0", req1_ready);
        end
        step();
        idle();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_add();
        int lat;
        bit seen;
        res_ready = 1'b1;
        send(REQ0, W'(5), W'(3), 1'b0);
        wait_result(lat, seen);
        checks += 4;
        if (!seen || lat != 3) begin
            failures++;
            $display("FAIL add_latency: got %0d seen=%b, required 3", lat, seen);
        end
        if (res_sum !== W'(8)) begin
            failures++; $display("FAIL add_sum: got %h, required 8", res_sum);
        end
        if (res_cout !== 1'b0) begin
            failures++; $display("FAIL add_cout: got %b, required 0", res_cout);
        end
        if (res_id !== 1'b0) begin
            failures++; $display("FAIL add_id: got %b, required 0", res_id);
        end
        step();
        wait_drain();
    endtask

    task automatic test_wrap_sub();
        int           lat;
        bit           seen;
        logic [W-1:0] ones;
        ones      = '1;
        res_ready = 1'b1;
        send(REQ1, ones, W'(1), 1'b0);
        wait_result(lat, seen);
        checks += 3;
        if (!seen || res_sum !== '0) begin
            failures++; $display("FAIL wrap_sum: got %h, required 0", res_sum);
        end
        if (res_cout !== 1'b1) begin
            failures++; $display("FAIL wrap_cout: got %b, required 1", res_cout);
        end
        if (res_id !== 1'b1) begin
            failures++; $display("FAIL wrap_id: got %b, required 1", res_id);
        end
        step();
        send(REQ1, '0, W'(1), 1'b1);
        wait_result(lat, seen);
        checks += 2;
        if (!seen || res_sum !== ones) begin
            failures++; $display("FAIL sub_sum: got %h, required %h", res_sum, ones);
        end
        if (res_cout !== 1'b0) begin
            failures++; $display("FAIL sub_cout: got %b, required 0", res_cout);
        end
        step();
        wait_drain();
    endtask

    task automatic test_round_robin();
        logic [9:0] vpat;
        logic       exp0;
        vpat      = '0;
        res_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            req0_valid = (c < 6);
            req1_valid = (c < 6);
            req0_x = W'(c * 11); req0_y = W'(c);     req0_sub = 1'b0;
            req1_x = W'(c * 7);  req1_y = W'(c + 2); req1_sub = 1'b1;
            @(negedge clk);
            if (c < 6) begin
                exp0 = (c % 2 == 0);
                checks++;
                if (req0_ready !== exp0 || req1_ready !== !exp0) begin
                    failures++;
                    $display("FAIL rr_grant%0d: got %b%b, required %b%b",
                             c, req0_ready, req1_ready, exp0, !exp0);
                end
            end
            vpat[c] = res_valid;
            step();
        end
        idle();
        checks++;
        if (vpat !== 10'b01_1111_1000) begin
            failures++;
            $display("FAIL rr_stream: got %b, required 0111111000", vpat);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int           issued;
        logic [W-1:0] held;
        logic         held_id;
        issued  = 0;
        held    = '0;
        held_id = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            res_ready  = !(cyc >= 3 && cyc < 8);
            req0_valid = (issued < 4);
            req0_x     = {W{1'b1}} >> issued;
            req0_y     = W'(issued * 3 + 1);
            req0_sub   = issued[0];
            @(negedge clk);
            if (cyc >= 3 && cyc < 8) begin
                checks += 2;
                if (res_valid !== 1'b1 || req0_ready !== 1'b0
                    || req1_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_hold%0d: got v=%b r0=%b r1=%b, required 1 0 0",
                             cyc, res_valid, req0_ready, req1_ready);
                end
                if (cyc == 3) begin
                    held    = res_sum;
                    held_id = res_id;
                end else if (res_sum !== held || res_id !== held_id) begin
                    failures++;
                    $display("FAIL bp_stable%0d: got %h, required %h",
                             cyc, res_sum, held);
                end
            end
            if (req0_ready) issued++;
            step();
        end
        idle();
        res_ready = 1'b1;
        checks++;
        if (issued != 4) begin
            failures++; $display("FAIL bp_issued: got %0d, required 4", issued);
        end
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        res_ready = 1'b1;
        send(REQ0, W'(100), W'(23), 1'b0);
        send(REQ0, W'(50), W'(60), 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_valid%0d: got %b, required 0", c, res_valid);
            end
            step();
        end
        req0_valid = 1'b1; req0_x = W'(1); req0_y = W'(2); req0_sub = 1'b0;
        req1_valid = 1'b1; req1_x = W'(3); req1_y = W'(4); req1_sub = 1'b0;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_tie: got %b%b, required 10", req0_ready, req1_ready);
        end
        step();
        idle();
        wait_drain();
    endtask

    task automatic test_random();
        int target;
        target = accepted + 10000;
        for (int c = 0; c < 60000 && accepted < target; c++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req0_x     = rand_op();
            req0_y     = rand_op();
            req0_sub   = $urandom_range(0, 1);
            req1_valid = ($urandom_range(0, 9) < 6);
            req1_x     = rand_op();
            req1_y     = rand_op();
            req1_sub   = $urandom_range(0, 1);
            res_ready  = ($urandom_range(0, 9) < 7);
            step();
        end
        idle();
        res_ready = 1'b1;
        checks++;
        if (accepted < target) begin
            failures++;
            $display("FAIL rand_timeout: got %0d ops, required %0d", accepted, target);
        end
        wait_drain();
    endtask

    initial begin
        rst = 1'b1;
        res_ready = 1'b0;
        req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_sub = 1'b0;
        test_reset();
        test_single_add();
        test_wrap_sub();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish by 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
